// File: rtl/cse141l_pkg.sv
// Shared CSE141L definitions: sequencer state encoding, PC width and halt opcode.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cse141l_pkg;

  // Fetch unit program counter width
  localparam int PC_W = 11;

  // Machine code of the halt instruction as recognised by the decoder
  localparam logic [8:0] HALT_OPCODE = 9'h1FF;

  // Program sequencer states
  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_ARMED = 3'd1,
    SEQ_LOAD  = 3'd2,
    SEQ_RUN   = 3'd3,
    SEQ_DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Latency: count visible one edge after enable; clear wins over enable.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Next count: clear first, otherwise step unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: arms on Start, loads a program base address, runs until Halt or PC bound fault.
// Latency: all outputs registered; LoadEn on the first edge with Start low, Done one edge after Halt.
// Backpressure: Start level holds the sequencer in ARMED; FetchHold stalls fetch outside RUN.
// Build option: PROG_SEQ_CYCLE_COUNT_EN adds the RUN cycle counter, otherwise CycleCount is 0.
module prog_sequencer #(
  parameter int PC_W     = cse141l_pkg::PC_W,
  parameter int BASE0    = 0,
  parameter int BASE1    = 256,
  parameter int BASE2    = 512,
  parameter int PC_LIMIT = 1023,
  parameter int CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       ProgSel,
  input  logic             Halt,
  input  logic [PC_W-1:0]  ProgCtr,
  output logic             FetchHold,
  output logic             LoadEn,
  output logic [PC_W-1:0]  LoadAddr,
  output logic             Busy,
  output logic             Done,
  output logic             Fault,
  output logic [1:0]       ProgIdx,
  output logic [CNT_W-1:0] CycleCount
);

  import cse141l_pkg::*;

  localparam logic [PC_W-1:0] PC_LIMIT_V = PC_W'(PC_LIMIT);

  seq_state_t      state_d, state_q;
  logic [1:0]      prog_idx_d, prog_idx_q;
  logic            done_d, done_q;
  logic            fault_d, fault_q;
  logic            fetch_hold_d, fetch_hold_q;
  logic            load_en_d, load_en_q;
  logic            busy_d, busy_q;
  logic [PC_W-1:0] load_addr_d, load_addr_q;
  logic [1:0]      sel_idx;
  logic            bound_err;

  // Start address of a program slot; slot 3 never reaches here because it is folded to 0
  function automatic logic [PC_W-1:0] base_of(input logic [1:0] idx);
    case (idx)
      2'd1:    base_of = PC_W'(BASE1);
      2'd2:    base_of = PC_W'(BASE2);
      default: base_of = PC_W'(BASE0);
    endcase
  endfunction

  assign sel_idx   = (ProgSel == 2'd3) ? 2'd0 : ProgSel;
  assign bound_err = (ProgCtr > PC_LIMIT_V) || ProgCtr[PC_W-1];

  // Next state and next registered outputs; outputs follow the state being entered
  always_comb begin
    state_d    = state_q;
    prog_idx_d = prog_idx_q;
    done_d     = done_q;
    fault_d    = fault_q;

    case (state_q)
      SEQ_IDLE, SEQ_DONE: begin
        if (Start) begin
          state_d    = SEQ_ARMED;
          prog_idx_d = sel_idx;
          done_d     = 1'b0;
          fault_d    = 1'b0;
        end
      end
      SEQ_ARMED: begin
        if (!Start) begin
          state_d = SEQ_LOAD;
        end
      end
      SEQ_LOAD: begin
        state_d = SEQ_RUN;
      end
      SEQ_RUN: begin
        // Abort beats halt, halt beats a bound fault
        if (Start) begin
          state_d    = SEQ_ARMED;
          prog_idx_d = sel_idx;
          done_d     = 1'b0;
          fault_d    = 1'b0;
        end else if (Halt) begin
          state_d = SEQ_DONE;
          done_d  = 1'b1;
          fault_d = 1'b0;
        end else if (bound_err) begin
          state_d = SEQ_DONE;
          done_d  = 1'b1;
          fault_d = 1'b1;
        end
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase

    fetch_hold_d = (state_d != SEQ_RUN);
    load_en_d    = (state_d == SEQ_LOAD);
    busy_d       = (state_d == SEQ_LOAD) || (state_d == SEQ_RUN);
    load_addr_d  = base_of(prog_idx_d);
  end

  // Sequencer state and registered outputs; reset overrides every input
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= SEQ_IDLE;
      prog_idx_q   <= 2'd0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      fetch_hold_q <= 1'b1;
      load_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      load_addr_q  <= PC_W'(BASE0);
    end else begin
      state_q      <= state_d;
      prog_idx_q   <= prog_idx_d;
      done_q       <= done_d;
      fault_q      <= fault_d;
      fetch_hold_q <= fetch_hold_d;
      load_en_q    <= load_en_d;
      busy_q       <= busy_d;
      load_addr_q  <= load_addr_d;
    end
  end

  assign FetchHold = fetch_hold_q;
  assign LoadEn    = load_en_q;
  assign LoadAddr  = load_addr_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Fault     = fault_q;
  assign ProgIdx   = prog_idx_q;

`ifdef PROG_SEQ_CYCLE_COUNT_EN
  logic cnt_clr;
  logic cnt_en;

  // Clear on every arm; count only edges that stay in RUN so the halt/fault edge is excluded
  assign cnt_clr = (state_d == SEQ_ARMED) && (state_q != SEQ_ARMED);
  assign cnt_en  = (state_q == SEQ_RUN) && (state_d == SEQ_RUN);

  sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .clk (Clk),
    .rst (Reset),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (CycleCount)
  );
`else
  assign CycleCount = '0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer with a small fetch-unit model and an expectation queue.
// Latency: each step drives inputs, pushes the expected registered outputs, then checks after the edge.
// Backpressure: n/a.
module tb_prog_sequencer;
  import cse141l_pkg::*;

  localparam int CW = 4;

  typedef struct packed {
    logic          fetch_hold;
    logic          load_en;
    logic [10:0]   load_addr;
    logic          busy;
    logic          done;
    logic          fault;
    logic [1:0]    idx;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          Clk = 1'b0;
  logic          Reset, Start, Halt;
  logic [1:0]    ProgSel;
  logic [10:0]   ProgCtr;
  logic          FetchHold, LoadEn, Busy, Done, Fault;
  logic [10:0]   LoadAddr;
  logic [1:0]    ProgIdx;
  logic [CW-1:0] CycleCount;

  logic [10:0]   pc;
  logic          force_en;
  logic [10:0]   force_val;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 Clk = ~Clk;

  prog_sequencer #(.CNT_W(CW)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .ProgSel    (ProgSel),
    .Halt       (Halt),
    .ProgCtr    (ProgCtr),
    .FetchHold  (FetchHold),
    .LoadEn     (LoadEn),
    .LoadAddr   (LoadAddr),
    .Busy       (Busy),
    .Done       (Done),
    .Fault      (Fault),
    .ProgIdx    (ProgIdx),
    .CycleCount (CycleCount)
  );

  // Fetch unit model: load overrides increment, hold parks the PC
  always @(posedge Clk) begin
    if (Reset)          pc <= 11'd0;
    else if (LoadEn)    pc <= LoadAddr;
    else if (!FetchHold) pc <= pc + 11'd1;
  end

  assign ProgCtr = force_en ? force_val : pc;

  function automatic logic [10:0] base_tb(input logic [1:0] idx);
    case (idx)
      2'd1:    return 11'd256;
      2'd2:    return 11'd512;
      default: return 11'd0;
    endcase
  endfunction

  function automatic logic [CW-1:0] cexp(input int n);
`ifdef PROG_SEQ_CYCLE_COUNT_EN
    return (n > 15) ? 4'd15 : CW'(n);
`else
    return (n < 0) ? 4'd1 : 4'd0;
`endif
  endfunction

  task automatic cmp(input string tag, input string fld, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, expv);
    end
  endtask

  task automatic push(input string tag, input seq_state_t st, input logic [1:0] idx,
                      input logic dn, input logic ft, input int n);
    exp_t e;
    e.fetch_hold = (st != SEQ_RUN);
    e.load_en    = (st == SEQ_LOAD);
    e.load_addr  = base_tb(idx);
    e.busy       = (st == SEQ_LOAD) || (st == SEQ_RUN);
    e.done       = dn;
    e.fault      = ft;
    e.idx        = idx;
    e.cnt        = cexp(n);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      cmp(t, "FetchHold",  16'(FetchHold),  16'(e.fetch_hold));
      cmp(t, "LoadEn",     16'(LoadEn),     16'(e.load_en));
      cmp(t, "LoadAddr",   16'(LoadAddr),   16'(e.load_addr));
      cmp(t, "Busy",       16'(Busy),       16'(e.busy));
      cmp(t, "Done",       16'(Done),       16'(e.done));
      cmp(t, "Fault",      16'(Fault),      16'(e.fault));
      cmp(t, "ProgIdx",    16'(ProgIdx),    16'(e.idx));
      cmp(t, "CycleCount", 16'(CycleCount), 16'(e.cnt));
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic step(input string tag, input seq_state_t st, input logic [1:0] idx,
                      input logic dn, input logic ft, input int n);
    push(tag, st, idx, dn, ft, n);
    tick();
    check_out();
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Halt = 1'b0; ProgSel = 2'd0;
    force_en = 1'b0; force_val = 11'd0;
    tick();
    step("reset", SEQ_IDLE, 2'd0, 1'b0, 1'b0, 0);
    Reset = 1'b0;
    step("idle", SEQ_IDLE, 2'd0, 1'b0, 1'b0, 0);

    // Launch program 1; ProgSel changes while armed must be ignored
    ProgSel = 2'd1; Start = 1'b1;
    step("arm1", SEQ_ARMED, 2'd1, 1'b0, 1'b0, 0);
    ProgSel = 2'd2;
    step("arm1_hold", SEQ_ARMED, 2'd1, 1'b0, 1'b0, 0);
    step("arm1_hold2", SEQ_ARMED, 2'd1, 1'b0, 1'b0, 0);
    Start = 1'b0;
    step("load1", SEQ_LOAD, 2'd1, 1'b0, 1'b0, 0);
    step("run1", SEQ_RUN, 2'd1, 1'b0, 1'b0, 0);
    cmp("launch1", "pc", 16'(pc), 16'd256);
    step("run1_b", SEQ_RUN, 2'd1, 1'b0, 1'b0, 1);

    // Abort into program 0, then halt after 10 executed instructions
    ProgSel = 2'd0; Start = 1'b1;
    step("arm0", SEQ_ARMED, 2'd0, 1'b0, 1'b0, 0);
    Start = 1'b0;
    step("load0", SEQ_LOAD, 2'd0, 1'b0, 1'b0, 0);
    step("run0", SEQ_RUN, 2'd0, 1'b0, 1'b0, 0);
    cmp("launch0", "pc", 16'(pc), 16'd0);
    for (int i = 1; i <= 10; i++) begin
      step("run0_cnt", SEQ_RUN, 2'd0, 1'b0, 1'b0, i);
    end
    Halt = 1'b1;
    step("halt0", SEQ_DONE, 2'd0, 1'b1, 1'b0, 10);
    Halt = 1'b0;
    step("done0_hold", SEQ_DONE, 2'd0, 1'b1, 1'b0, 10);
    cmp("halt_park", "pc", 16'(pc), 16'd11);

    // PC bound: 1023 legal, 1024 faults
    Start = 1'b1;
    step("arm_b", SEQ_ARMED, 2'd0, 1'b0, 1'b0, 0);
    Start = 1'b0;
    step("load_b", SEQ_LOAD, 2'd0, 1'b0, 1'b0, 0);
    step("run_b", SEQ_RUN, 2'd0, 1'b0, 1'b0, 0);
    force_en = 1'b1; force_val = 11'd1023;
    step("pc_limit_ok", SEQ_RUN, 2'd0, 1'b0, 1'b0, 1);
    force_val = 11'd1024;
    step("bound_fault", SEQ_DONE, 2'd0, 1'b1, 1'b1, 1);
    force_en = 1'b0;

    // Bound violation together with Halt: halt wins
    Start = 1'b1;
    step("arm_bh", SEQ_ARMED, 2'd0, 1'b0, 1'b0, 0);
    Start = 1'b0;
    step("load_bh", SEQ_LOAD, 2'd0, 1'b0, 1'b0, 0);
    step("run_bh", SEQ_RUN, 2'd0, 1'b0, 1'b0, 0);
    force_en = 1'b1; force_val = 11'd1024; Halt = 1'b1;
    step("bound_halt", SEQ_DONE, 2'd0, 1'b1, 1'b0, 0);
    force_en = 1'b0; Halt = 1'b0;

    // Program 2, then abort with ProgSel=3 while Halt is also high
    ProgSel = 2'd2; Start = 1'b1;
    step("arm2", SEQ_ARMED, 2'd2, 1'b0, 1'b0, 0);
    Start = 1'b0;
    step("load2", SEQ_LOAD, 2'd2, 1'b0, 1'b0, 0);
    step("run2", SEQ_RUN, 2'd2, 1'b0, 1'b0, 0);
    cmp("launch2", "pc", 16'(pc), 16'd512);
    for (int i = 1; i <= 3; i++) begin
      step("run2_cnt", SEQ_RUN, 2'd2, 1'b0, 1'b0, i);
    end
    ProgSel = 2'd3; Start = 1'b1; Halt = 1'b1;
    step("abort", SEQ_ARMED, 2'd0, 1'b0, 1'b0, 0);
    Start = 1'b0; Halt = 1'b0;
    step("abort_load", SEQ_LOAD, 2'd0, 1'b0, 1'b0, 0);
    step("abort_run", SEQ_RUN, 2'd0, 1'b0, 1'b0, 0);

    // Counter saturation across 20 RUN edges
    for (int i = 1; i <= 20; i++) begin
      step("saturate", SEQ_RUN, 2'd0, 1'b0, 1'b0, i);
    end

    // Reset mid-RUN for two cycles, with Start high to show reset priority
    Reset = 1'b1; Start = 1'b1;
    step("reset_run", SEQ_IDLE, 2'd0, 1'b0, 1'b0, 0);
    step("reset_run2", SEQ_IDLE, 2'd0, 1'b0, 1'b0, 0);
    Reset = 1'b0; ProgSel = 2'd1;
    step("post_reset_arm", SEQ_ARMED, 2'd1, 1'b0, 1'b0, 0);
    Start = 1'b0;
    step("post_reset_load", SEQ_LOAD, 2'd1, 1'b0, 1'b0, 0);

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Program sequencer for the CSE141L core. It owns the fetch unit's `Start` hold input and a PC-load path, and launches one of three programs from a fixed start address on each `Start` handshake. It stops the fetch unit on a halt instruction or on a PC bound violation, and reports `Done` to the testbench. It also counts executed cycles per program run.

## Interface

**Parameters**
- `PC_W`, default 11: program counter width; matches the fetch unit's `ProgCtr`.
- `BASE0`, default 0: start address of program 0.
- `BASE1`, default 256: start address of program 1.
- `BASE2`, default 512: start address of program 2.
- `PC_LIMIT`, default 1023: highest legal PC. A PC above this value is a fault.
- `CNT_W`, default 16: width of the cycle counter.

**Ports**
- `Clk`, in, 1: single clock. All state changes on posedge.
- `Reset`, in, 1: synchronous, active-high reset.
- `Start`, in, 1: testbench request. A program is armed while high and launched on the falling edge.
- `ProgSel`, in, 2: program index, sampled on the cycle `Start` first rises. A value of 3 is treated as 0.
- `Halt`, in, 1: from the decoder. High while the current instruction is the halt opcode.
- `ProgCtr`, in, `PC_W`: current PC from the fetch unit.
- `FetchHold`, out, 1: drives the fetch unit's `Start`. High holds the PC.
- `LoadEn`, out, 1: one-cycle pulse that forces the fetch PC to `LoadAddr`.
- `LoadAddr`, out, `PC_W`: start address of the selected program.
- `Busy`, out, 1: high in states LOAD and RUN.
- `Done`, out, 1: level signal. Held in state DONE until the next `Start` rise.
- `Fault`, out, 1: valid with `Done`. Set when the run ended on a PC bound violation rather than on `Halt`.
- `ProgIdx`, out, 2: latched program index.
- `CycleCount`, out, `CNT_W`: number of cycles spent in RUN (only with `CYCLE_COUNT_EN`).

## Operation

**States**
- IDLE: entered on reset.
- ARMED: `Start` is high and the program index has been captured.
- LOAD: one cycle; the start address is loaded into the fetch unit.
- RUN: the program executes.
- DONE: the run has ended and results are reported.

**Transitions**
- IDLE to ARMED when `Start`=1. Latch `ProgIdx` from `ProgSel`, with 3 mapped to 0. Clear `Done`, `Fault` and `CycleCount`.
- ARMED stays in ARMED while `Start`=1. On `Start`=0 it moves to LOAD.
- LOAD to RUN unconditionally. In LOAD, `LoadEn`=1 and `LoadAddr`=`BASE[ProgIdx]`. `FetchHold`=1 is held through LOAD.
- In RUN, `FetchHold`=0.
  - RUN to DONE when `Halt`=1, with `Fault`=0.
  - RUN to DONE when `ProgCtr` > `PC_LIMIT` or `ProgCtr` is negative (MSB set), with `Fault`=1.
  - If `Halt` and a bound violation occur in the same cycle, `Halt` wins and `Fault`=0.
- RUN to ARMED when `Start`=1. This aborts the run, re-latches `ProgSel` and clears the counter.
- DONE to ARMED when `Start`=1. In DONE, `FetchHold`=1.
- `LoadAddr` is driven to `BASE[ProgIdx]` in every state. Only `LoadEn` qualifies it.

**Outputs by state**
- `FetchHold` is 1 in every state except RUN.

**Reset values**
- State IDLE.
- `FetchHold`=1, `LoadEn`=0, `Busy`=0, `Done`=0, `Fault`=0, `ProgIdx`=0, `CycleCount`=0.
- `LoadAddr`=`BASE0`.
- Reset in any state, including mid-RUN, forces these values on the next edge. Reset takes priority over every other input.

## Timing

- `Start` fall to `LoadEn`: the sequencer enters LOAD on the first edge at which `Start`=0, and `LoadEn` is high for that cycle.
- Fetch PC equals `BASE[ProgIdx]` one edge after LOAD. The first RUN cycle presents the first instruction.
- `Halt` to `Done`: `Done` and `FetchHold` are high one edge after `Halt` is sampled. The PC stays parked at the halt address plus at most one increment; the halt cycle itself is not counted.
- `CycleCount` increments on every edge spent in RUN and saturates at all-ones (no wrap).
- All outputs are registered. There are no combinational paths from inputs to outputs.
- A `Start` rise in the same cycle as `Halt` in RUN: `Start` wins and the next state is ARMED.

## Configuration

- `PROG_SEQ_CYCLE_COUNT_EN` defined: the `CNT_W` saturating counter is present and `CycleCount` reports it.
- Not defined: the counter is not built and `CycleCount` is tied to 0. All other behaviour is identical.

## Structure

- A shared package `cse141l_pkg` holds:
  - the state enum (`SEQ_IDLE`, `SEQ_ARMED`, `SEQ_LOAD`, `SEQ_RUN`, `SEQ_DONE`);
  - `PC_W`;
  - the halt opcode constant used by the decoder.
- The base addresses stay as module parameters.
- One sub-module, `sat_counter`, implements the saturating counter with clear and enable. It is instantiated only under `PROG_SEQ_CYCLE_COUNT_EN`.
- The fetch unit needs a load-enable port added so that `LoadEn`/`LoadAddr` override both increment and branch.

## Test plan

- **Reset:** `Reset` high for 2 cycles mid-RUN → next edge gives IDLE, `FetchHold`=1, `Done`=0, `CycleCount`=0.
- **Launch program 1:** `ProgSel`=1, `Start` high for 3 cycles then low → `LoadEn` pulses for 1 cycle with `LoadAddr`=256, and the fetch PC is 256 on the next edge.
- **Normal halt:** program 0 runs 10 instructions, then `Halt` is asserted → `Done`=1, `Fault`=0, `FetchHold`=1, `CycleCount`=10 (with `PROG_SEQ_CYCLE_COUNT_EN`).
- **Bound fault:** force `ProgCtr`=1024 in RUN → `Done`=1 and `Fault`=1 the next edge. Repeat with `Halt` in the same cycle → `Fault`=0.
- **Abort:** `Start` rises during RUN of program 2 with `ProgSel`=3 → state ARMED, `ProgIdx`=0, counter cleared; release `Start` → `LoadAddr`=0.
- **Saturation:** with `CNT_W`=4, run 20 cycles without `Halt` → `CycleCount` holds 15.
